// File: rtl/kernel_cfg_pkg.sv
// -----------------------------------------------------------------------------
// kernel_cfg_pkg
// Shared definitions for the stage-2 kernel configuration unit:
//   - kmode_e  : kernel source encodings carried on `mode`
//   - kstate_e : control FSM states
//   - the 3x3 preset cores (Laplacian, identity, sharpen, box)
//   - params_ok(): parameter legality check used at elaboration time
// -----------------------------------------------------------------------------
package kernel_cfg_pkg;

    typedef enum logic [2:0] {
        KM_LAPLACIAN = 3'd0,
        KM_IDENTITY  = 3'd1,
        KM_SHARPEN   = 3'd2,
        KM_BOX       = 3'd3,
        KM_CUSTOM    = 3'd4
    } kmode_e;

    typedef enum logic [1:0] {
        KS_IDLE   = 2'd0,
        KS_COMMIT = 2'd1,
        KS_NOTIFY = 2'd2
    } kstate_e;

    // 3x3 cores, row-major, top-left first.
    localparam int LAPLACIAN_CORE [9] = '{0, -1, 0, -1, 4, -1, 0, -1, 0};
    localparam int SHARPEN_CORE   [9] = '{0, -1, 0, -1, 5, -1, 0, -1, 0};

    // Coefficient of a preset core at position idx (0..8). Modes without a
    // preset (custom, reserved) yield 0.
    function automatic int core_coef(input logic [2:0] mode, input int idx);
        int v;
        v = 0;
        case (mode)
            KM_LAPLACIAN: v = LAPLACIAN_CORE[idx];
            KM_IDENTITY:  v = (idx == 4) ? 1 : 0;
            KM_SHARPEN:   v = SHARPEN_CORE[idx];
            KM_BOX:       v = 1;
            default:      v = 0;
        endcase
        return v;
    endfunction

    // K must be odd and at least 3 so the 3x3 core has a centre; CW must hold
    // the largest preset value (+5) as a signed number.
    function automatic bit params_ok(input int k, input int cw);
        return (k >= 3) && ((k % 2) == 1) && (cw >= 4);
    endfunction

endpackage

// File: rtl/kernel_preset_rom.sv
// -----------------------------------------------------------------------------
// kernel_preset_rom
// Combinational preset table: maps a kernel mode to a flat K*K*CW bus holding
// the mode's 3x3 core centred in a KxK kernel, all other cells zero.
// Ports:
//   mode   in  3        kernel mode (kmode_e encoding)
//   preset out K*K*CW   slot (r*K+c) at [(r*K+c)*CW +: CW]; slot 0 = top-left
// -----------------------------------------------------------------------------
module kernel_preset_rom #(
    parameter int K  = 3,
    parameter int CW = 4
) (
    input  logic [2:0]        mode,
    output logic [K*K*CW-1:0] preset
);
    import kernel_cfg_pkg::*;

    if (!params_ok(K, CW)) begin : g_param_check
        $error("kernel_preset_rom: K must be odd and >= 3, CW must be >= 4");
    end

    // Row/column of the top-left cell of the centred 3x3 core.
    localparam int OFF = (K - 3) / 2;

    always_comb begin
        preset = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                // Truncating the int to CW bits is exactly sign extension
                // for these small constants.
                preset[((r + OFF) * K + (c + OFF)) * CW +: CW] = CW'(core_coef(mode, r * 3 + c));
            end
        end
    end

endmodule

// File: rtl/kernel_config_unit.sv
// -----------------------------------------------------------------------------
// kernel_config_unit
// KxK signed coefficient bank for convolution stage 2. A kernel is taken from
// the preset ROM or from a streamed shadow bank and committed atomically to
// the active bank on `start`; stage 3 is then notified with `stage3_start`.
//
// Load handshake: a beat transfers on a rising edge where
// load_valid && load_ready; load_ready drops only in COMMIT, so the shadow
// bank is never written while it may be copied to the active bank.
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   start, mode   commit request and kernel source (sampled in IDLE)
//   load_valid    coefficient beat valid
//   load_data     CW-bit signed coefficient, row-major, top-left first
//   load_ready    beat accepted when load_valid && load_ready
//   coef          active kernel, slot (r*K+c) at [(r*K+c)*CW +: CW]
//   kernel_valid  active bank holds a committed kernel
//   stage3_start  one-cycle pulse after each successful commit
//   busy          high outside IDLE
//   err           one-cycle pulse on a rejected commit
//   state_dbg     current FSM state (kstate_e encoding), for observation
// -----------------------------------------------------------------------------
module kernel_config_unit #(
    parameter int K  = 3,
    parameter int CW = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        mode,
    input  logic              load_valid,
    input  logic [CW-1:0]     load_data,
    output logic              load_ready,
    output logic [K*K*CW-1:0] coef,
    output logic              kernel_valid,
    output logic              stage3_start,
    output logic              busy,
    output logic              err,
    output logic [1:0]        state_dbg
);
    import kernel_cfg_pkg::*;

    if (!params_ok(K, CW)) begin : g_param_check
        $error("kernel_config_unit: K must be odd and >= 3, CW must be >= 4");
    end

    localparam int NSLOT = K * K;
    localparam int NW    = NSLOT * CW;
    localparam int IDX_W = $clog2(NSLOT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLOT - 1);

    kstate_e          state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             shadow_full_q, shadow_full_d;
    logic [NW-1:0]    shadow_q, shadow_d;
    logic [NW-1:0]    active_q, active_d;
    logic             kernel_valid_q, kernel_valid_d;
    logic             stage3_start_q, stage3_start_d;
    logic             err_q, err_d;

    logic [NW-1:0]    preset;
    logic             beat_acc;

    kernel_preset_rom #(.K(K), .CW(CW)) u_rom (
        .mode   (mode_q),
        .preset (preset)
    );

    assign load_ready   = (state_q != KS_COMMIT);
    assign beat_acc     = load_valid && load_ready;
    assign coef         = active_q;
    assign kernel_valid = kernel_valid_q;
    assign stage3_start = stage3_start_q;
    assign err          = err_q;
    assign busy         = (state_q != KS_IDLE);
    assign state_dbg    = state_q;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        idx_d          = idx_q;
        shadow_full_d  = shadow_full_q;
        shadow_d       = shadow_q;
        active_d       = active_q;
        kernel_valid_d = kernel_valid_q;
        stage3_start_d = 1'b0;
        err_d          = 1'b0;

        // Shadow streaming. Never active in COMMIT, so it cannot collide
        // with the idx/shadow_full clear done by a custom commit below.
        if (beat_acc) begin
            shadow_d[idx_q * CW +: CW] = load_data;
            if (idx_q == LAST_IDX) begin
                idx_d         = '0;
                shadow_full_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end

        case (state_q)
            KS_IDLE: begin
                if (start) begin
                    state_d = KS_COMMIT;
                    mode_d  = mode;
                end
            end
            KS_COMMIT: begin
                if (mode_q < 3'(KM_CUSTOM)) begin
                    active_d       = preset;
                    kernel_valid_d = 1'b1;
                    stage3_start_d = 1'b1;
                    state_d        = KS_NOTIFY;
                end else if ((mode_q == 3'(KM_CUSTOM)) && shadow_full_q) begin
                    active_d       = shadow_q;
                    shadow_full_d  = 1'b0;
                    idx_d          = '0;
                    kernel_valid_d = 1'b1;
                    stage3_start_d = 1'b1;
                    state_d        = KS_NOTIFY;
                end else begin
                    // Incomplete shadow or reserved mode: active bank kept.
                    err_d   = 1'b1;
                    state_d = KS_IDLE;
                end
            end
            KS_NOTIFY: begin
                state_d = KS_IDLE;
            end
            default: begin
                state_d = KS_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= KS_IDLE;
            mode_q         <= '0;
            idx_q          <= '0;
            shadow_full_q  <= 1'b0;
            shadow_q       <= '0;
            active_q       <= '0;
            kernel_valid_q <= 1'b0;
            stage3_start_q <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            idx_q          <= idx_d;
            shadow_full_q  <= shadow_full_d;
            shadow_q       <= shadow_d;
            active_q       <= active_d;
            kernel_valid_q <= kernel_valid_d;
            stage3_start_q <= stage3_start_d;
            err_q          <= err_d;
        end
    end

endmodule

// File: tb/tb_kernel_config_unit.sv
// -----------------------------------------------------------------------------
// tb_kernel_config_unit
// Table-driven bench for kernel_config_unit (K=3, CW=4) plus a K=5 instance
// for the centred-preset check. Inputs change on the falling edge; outputs
// are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_kernel_config_unit;

    localparam int K  = 3;
    localparam int CW = 4;
    localparam int NW = K * K * CW;

    logic          clk;
    logic          rst;
    logic          start;
    logic [2:0]    mode;
    logic          load_valid;
    logic [CW-1:0] load_data;
    logic          load_ready;
    logic [NW-1:0] coef;
    logic          kernel_valid;
    logic          stage3_start;
    logic          busy;
    logic          err;
    logic [1:0]    state_dbg;

    logic          start5;
    logic [2:0]    mode5;
    logic          load_valid5;
    logic [3:0]    load_data5;
    logic          load_ready5;
    logic [99:0]   coef5;
    logic          kernel_valid5;
    logic          stage3_start5;
    logic          busy5;
    logic          err5;
    logic [1:0]    state_dbg5;

    int n_checks;
    int n_pass;

    kernel_config_unit #(.K(K), .CW(CW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .load_valid   (load_valid),
        .load_data    (load_data),
        .load_ready   (load_ready),
        .coef         (coef),
        .kernel_valid (kernel_valid),
        .stage3_start (stage3_start),
        .busy         (busy),
        .err          (err),
        .state_dbg    (state_dbg)
    );

    kernel_config_unit #(.K(5), .CW(4)) dut5 (
        .clk          (clk),
        .rst          (rst),
        .start        (start5),
        .mode         (mode5),
        .load_valid   (load_valid5),
        .load_data    (load_data5),
        .load_ready   (load_ready5),
        .coef         (coef5),
        .kernel_valid (kernel_valid5),
        .stage3_start (stage3_start5),
        .busy         (busy5),
        .err          (err5),
        .state_dbg    (state_dbg5)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected K=3 bus from nine slot values, slot 0 in the low bits.
    function automatic logic [35:0] pk3(input int s0, input int s1, input int s2,
                                        input int s3, input int s4, input int s5,
                                        input int s6, input int s7, input int s8);
        return {4'(s8), 4'(s7), 4'(s6), 4'(s5), 4'(s4), 4'(s3), 4'(s2), 4'(s1), 4'(s0)};
    endfunction

    typedef struct {
        logic [2:0]  mode;
        int          nbeats;
        int          first;
        bit          exp_err;
        logic [35:0] exp_coef;
    } vec_t;

    vec_t vecs [12];

    // Streams nbeats coefficients first, first+1, ... (start rides with the
    // last beat), then checks the COMMIT cycle, the result cycle and the
    // return to IDLE.
    task automatic do_commit(input string tag, input logic [2:0] m, input int nbeats,
                             input int first, input bit exp_err,
                             input logic [35:0] exp_coef, input bit exp_kv);
        if (nbeats == 0) begin
            @(negedge clk);
            start = 1'b1;
            mode  = m;
        end else begin
            for (int i = 0; i < nbeats; i++) begin
                @(negedge clk);
                load_valid = 1'b1;
                load_data  = 4'(first + i);
                start      = (i == nbeats - 1);
                mode       = m;
            end
        end
        @(negedge clk);
        start      = 1'b0;
        load_valid = 1'b0;
        chk({tag, " commit busy"}, busy, 1'b1);
        chk({tag, " commit load_ready"}, load_ready, 1'b0);
        chk({tag, " commit stage3_start"}, stage3_start, 1'b0);
        @(negedge clk);
        chk({tag, " stage3_start"}, stage3_start, !exp_err);
        chk({tag, " err"}, err, exp_err);
        chk({tag, " coef"}, coef, exp_coef);
        chk({tag, " kernel_valid"}, kernel_valid, exp_kv);
        @(negedge clk);
        chk({tag, " idle stage3_start"}, stage3_start, 1'b0);
        chk({tag, " idle err"}, err, 1'b0);
        chk({tag, " idle busy"}, busy, 1'b0);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " coef"}, coef, '0);
        chk({tag, " kernel_valid"}, kernel_valid, 1'b0);
        chk({tag, " stage3_start"}, stage3_start, 1'b0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " err"}, err, 1'b0);
        chk({tag, " load_ready"}, load_ready, 1'b1);
    endtask

    initial begin
        logic [35:0] lap;
        logic [35:0] ident;
        logic [35:0] sharp;
        logic [35:0] box;
        logic [35:0] cust1;
        logic [35:0] cust2;
        logic [35:0] cust3;
        int          pulses;
        logic [3:0]  exp5;

        n_checks = 0;
        n_pass   = 0;

        lap   = pk3(0, -1, 0, -1, 4, -1, 0, -1, 0);
        ident = pk3(0, 0, 0, 0, 1, 0, 0, 0, 0);
        sharp = pk3(0, -1, 0, -1, 5, -1, 0, -1, 0);
        box   = pk3(1, 1, 1, 1, 1, 1, 1, 1, 1);
        cust1 = pk3(1, 2, 3, 4, 5, 6, 7, 8, 9);
        // 4 beats 10..13 (rejected commit keeps them), then 5 beats 14..18
        // truncated to 4 bits complete the bank.
        cust2 = pk3(10, 11, 12, 13, 14, 15, 0, 1, 2);
        // 11 beats 3..13: the last two wrap onto slots 0 and 1.
        cust3 = pk3(12, 13, 5, 6, 7, 8, 9, 10, 11);

        //            mode  beats first err  coef
        vecs[0]  = '{3'd0, 0,    0,    1'b0, lap};
        vecs[1]  = '{3'd1, 0,    0,    1'b0, ident};
        vecs[2]  = '{3'd2, 0,    0,    1'b0, sharp};
        vecs[3]  = '{3'd3, 0,    0,    1'b0, box};
        vecs[4]  = '{3'd4, 9,    1,    1'b0, cust1};
        vecs[5]  = '{3'd4, 0,    0,    1'b1, cust1};
        vecs[6]  = '{3'd4, 4,    10,   1'b1, cust1};
        vecs[7]  = '{3'd6, 0,    0,    1'b1, cust1};
        vecs[8]  = '{3'd4, 5,    14,   1'b0, cust2};
        vecs[9]  = '{3'd7, 0,    0,    1'b1, cust2};
        vecs[10] = '{3'd4, 11,   3,    1'b0, cust3};
        vecs[11] = '{3'd3, 2,    0,    1'b0, box};

        rst         = 1'b1;
        start       = 1'b0;
        mode        = 3'd0;
        load_valid  = 1'b0;
        load_data   = '0;
        start5      = 1'b0;
        mode5       = 3'd0;
        load_valid5 = 1'b0;
        load_data5  = '0;
        repeat (3) @(negedge clk);
        chk_reset_values("rst held");
        rst = 1'b0;
        @(negedge clk);
        chk_reset_values("after rst");
        chk("k5 reset coef", coef5, '0);

        for (int v = 0; v < 12; v++) begin
            do_commit($sformatf("vec%0d", v), vecs[v].mode, vecs[v].nbeats,
                      vecs[v].first, vecs[v].exp_err, vecs[v].exp_coef, 1'b1);
        end

        // start held high across COMMIT and NOTIFY: only one commit.
        @(negedge clk);
        start  = 1'b1;
        mode   = 3'd1;
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (stage3_start) pulses++;
            if (i == 1) start = 1'b0;
        end
        chk("held start pulses", 32'(pulses), 32'd1);
        chk("held start coef", coef, ident);

        // K=5 sharpen: core centred on slot 12.
        @(negedge clk);
        start5 = 1'b1;
        mode5  = 3'd2;
        @(negedge clk);
        start5 = 1'b0;
        @(negedge clk);
        chk("k5 stage3_start", stage3_start5, 1'b1);
        for (int s = 0; s < 25; s++) begin
            if (s == 12) exp5 = 4'h5;
            else if (s == 7 || s == 11 || s == 13 || s == 17) exp5 = 4'hF;
            else exp5 = 4'h0;
            chk($sformatf("k5 slot%0d", s), coef5[s*4 +: 4], exp5);
        end

        // Reset during COMMIT with the shadow partly loaded.
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            load_valid = 1'b1;
            load_data  = 4'(i + 1);
        end
        @(negedge clk);
        load_valid = 1'b0;
        start      = 1'b1;
        mode       = 3'd4;
        @(negedge clk);
        start = 1'b0;
        chk("pre-rst in commit", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk_reset_values("mid rst");
        @(negedge clk);
        rst = 1'b0;
        do_commit("post-rst custom", 3'd4, 0, 0, 1'b1, 36'h0, 1'b0);
        // A full load after reset must land from slot 0.
        do_commit("post-rst reload", 3'd4, 9, 5, 1'b0,
                  pk3(5, 6, 7, 8, 9, 10, 11, 12, 13), 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
